// File: rtl/alu_exec_unit_if.sv
// Operand/result handshake bundle for alu_exec_unit: request side (in_*) and result side (out_*).
interface alu_exec_unit_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_alu_ctrl;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;

  modport master (
    output in_valid, in_alu_ctrl, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag, out_err
  );

  modport slave (
    input  in_valid, in_alu_ctrl, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag, out_err
  );
endinterface

// File: rtl/alu_exec_unit.sv
// RV32I execute-stage ALU: valid/ready request in, valid/ready result out, 1 bit/cycle shifter.
// Define ALU_FAST_SHIFT_EN to replace the iterative shifter with a single-cycle barrel shifter.
module alu_exec_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  alu_exec_unit_if.slave bus
);
  localparam int SH_W = $clog2(XLEN);
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_SLL = 4'd2, OP_SLT = 4'd3,
                         OP_SLTU = 4'd4, OP_XOR = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7,
                         OP_OR = 4'd8, OP_AND = 4'd9;

  logic             ready_en;
  logic             out_valid_q;
  logic [XLEN-1:0]  result_q;
  logic [TAG_W-1:0] tag_q;
  logic             err_q;
  logic [SH_W-1:0]  shamt;
  logic             is_shift;
  logic             in_ready;
  logic             accept;
  logic             fsm_idle;
  logic             load_direct;
  logic             shift_done;
  logic [XLEN-1:0]  shift_res;
  logic [TAG_W-1:0] shift_tag;
  logic [XLEN-1:0]  alu_res;
  logic             alu_err;

  assign shamt    = bus.in_b[SH_W-1:0];
  assign is_shift = (bus.in_alu_ctrl == OP_SLL) || (bus.in_alu_ctrl == OP_SRL) ||
                    (bus.in_alu_ctrl == OP_SRA);
  assign in_ready = ready_en & fsm_idle & (~out_valid_q | bus.out_ready) & ~flush;
  assign accept   = bus.in_valid & in_ready;

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = result_q;
  assign bus.out_tag    = tag_q;
  assign bus.out_err    = err_q;

  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (bus.in_alu_ctrl)
      OP_ADD:  alu_res = bus.in_a + bus.in_b;
      OP_SUB:  alu_res = bus.in_a - bus.in_b;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(bus.in_a) < $signed(bus.in_b)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, bus.in_a < bus.in_b};
      OP_XOR:  alu_res = bus.in_a ^ bus.in_b;
      OP_OR:   alu_res = bus.in_a | bus.in_b;
      OP_AND:  alu_res = bus.in_a & bus.in_b;
`ifdef ALU_FAST_SHIFT_EN
      OP_SLL:  alu_res = bus.in_a << shamt;
      OP_SRL:  alu_res = bus.in_a >> shamt;
      OP_SRA:  alu_res = XLEN'($signed(bus.in_a) >>> shamt);
`else
      // only zero shift amounts complete here; the rest go through SHIFT
      OP_SLL, OP_SRL, OP_SRA: alu_res = bus.in_a;
`endif
      default: alu_err = 1'b1;
    endcase
  end

`ifdef ALU_FAST_SHIFT_EN
  assign fsm_idle    = 1'b1;
  assign load_direct = accept;
  assign shift_done  = 1'b0;
  assign shift_res   = '0;
  assign shift_tag   = '0;
`else
  // state | meaning
  // IDLE  | accepting requests; non-shifts and zero-amount shifts finish in one cycle
  // SHIFT | work_q shifts one bit per cycle; cnt_q holds the bits still to go
  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [SH_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]  work_q, work_d;
  logic [1:0]       kind_q;
  logic [TAG_W-1:0] sh_tag_q;
  logic             shift_start;

  assign shift_start = accept & is_shift & (shamt != '0);
  assign load_direct = accept & ~shift_start;
  assign fsm_idle    = (state_q == IDLE);
  assign shift_tag   = sh_tag_q;

  always_comb begin
    case (kind_q)
      2'd0:    shift_res = {work_q[XLEN-2:0], 1'b0};
      2'd1:    shift_res = {1'b0, work_q[XLEN-1:1]};
      default: shift_res = {work_q[XLEN-1], work_q[XLEN-1:1]};
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    work_d     = work_q;
    shift_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (shift_start) begin
          state_d = SHIFT;
          cnt_d   = shamt;
          work_d  = bus.in_a;
        end
      end
      SHIFT: begin
        work_d = shift_res;
        cnt_d  = cnt_q - SH_W'(1);
        if (cnt_q == SH_W'(1)) begin
          shift_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d    = IDLE;
      cnt_d      = '0;
      work_d     = work_q;
      shift_done = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      work_q   <= '0;
      kind_q   <= 2'd0;
      sh_tag_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      if (shift_start) begin
        kind_q   <= (bus.in_alu_ctrl == OP_SLL) ? 2'd0 :
                    (bus.in_alu_ctrl == OP_SRL) ? 2'd1 : 2'd2;
        sh_tag_q <= bus.in_tag;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en    <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      tag_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (flush) begin
        out_valid_q <= 1'b0;
      end else if (load_direct) begin
        out_valid_q <= 1'b1;
        result_q    <= alu_res;
        tag_q       <= bus.in_tag;
        err_q       <= alu_err;
      end else if (shift_done) begin
        out_valid_q <= 1'b1;
        result_q    <= shift_res;
        tag_q       <= shift_tag;
        err_q       <= 1'b0;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: scoreboard of expected results plus per-scenario tasks.
module tb_alu_exec_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   pops = 0;

  typedef struct packed {
    logic [31:0] r;
    logic [4:0]  t;
    logic        e;
  } exp_t;

  exp_t sb[$];

  alu_exec_unit_if #(.XLEN(32), .TAG_W(5)) bif();

  alu_exec_unit #(.XLEN(32), .TAG_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bif.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [3:0] c, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] t);
    exp_t x;
    x.t = t;
    x.e = 1'b0;
    case (c)
      4'd0: x.r = a + b;
      4'd1: x.r = a - b;
      4'd2: x.r = a << b[4:0];
      4'd3: x.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4: x.r = (a < b) ? 32'd1 : 32'd0;
      4'd5: x.r = a ^ b;
      4'd6: x.r = a >> b[4:0];
      4'd7: x.r = 32'($signed(a) >>> b[4:0]);
      4'd8: x.r = a | b;
      4'd9: x.r = a & b;
      default: begin x.r = 32'd0; x.e = 1'b1; end
    endcase
    return x;
  endfunction

  // scoreboard: every completed output transfer is matched against the oldest expectation
  always @(negedge clk) begin
    if (rst_n && bif.out_valid && bif.out_ready) begin
      exp_t x;
      checks++;
      pops++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got result=%h tag=%0d err=%b, expected no output",
                 bif.out_result, bif.out_tag, bif.out_err);
      end else begin
        x = sb.pop_front();
        if (bif.out_result !== x.r || bif.out_tag !== x.t || bif.out_err !== x.e) begin
          errors++;
          $display("FAIL sb_compare: got result=%h tag=%0d err=%b, expected result=%h tag=%0d err=%b",
                   bif.out_result, bif.out_tag, bif.out_err, x.r, x.t, x.e);
        end
      end
    end
  end

  // starts and ends one time unit after a rising edge
  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] t, input bit push);
    bit ok = 1'b0;
    bif.in_valid = 1'b1; bif.in_alu_ctrl = c; bif.in_a = a; bif.in_b = b; bif.in_tag = t;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk); ok = bif.in_ready;
      @(posedge clk); #1;
      if (ok) break;
    end
    bif.in_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL issue_timeout: tag=%0d in_ready=0 for 200 cycles, expected 1", t);
    end else if (push) begin
      sb.push_back(model(c, a, b, t));
    end
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 100; k++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bif.in_valid = 0; bif.in_alu_ctrl = 0; bif.in_a = 0; bif.in_b = 0; bif.in_tag = 0;
    bif.out_ready = 0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    checks += 5;
    if (bif.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b expected 0", bif.in_ready); end
    if (bif.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", bif.out_valid); end
    if (bif.out_result !== 32'd0) begin errors++; $display("FAIL rst_result: got %h expected 0", bif.out_result); end
    if (bif.out_tag !== 5'd0) begin errors++; $display("FAIL rst_tag: got %0d expected 0", bif.out_tag); end
    if (bif.out_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", bif.out_err); end
    @(posedge clk); #1; rst_n = 1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bif.in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b expected 1", bif.in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_arith();
    logic [3:0] ops [7] = '{4'd0, 4'd1, 4'd3, 4'd4, 4'd5, 4'd8, 4'd9};
    bif.out_ready = 1;
    issue(4'd0, 32'h7FFF_FFFF, 32'd1, 5'd3, 1'b1);
    @(negedge clk);
    checks++;
    if (bif.out_valid !== 1'b1 || bif.out_result !== 32'h8000_0000 || bif.out_tag !== 5'd3 || bif.out_err !== 1'b0) begin
      errors++;
      $display("FAIL add_overflow: got valid=%b result=%h tag=%0d err=%b expected 1 80000000 3 0",
               bif.out_valid, bif.out_result, bif.out_tag, bif.out_err);
    end
    @(posedge clk); #1;
    issue(4'd1, 32'd0, 32'd1, 5'd4, 1'b1);
    @(negedge clk);
    checks++;
    if (bif.out_result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sub_wrap: got %h expected ffffffff", bif.out_result); end
    @(posedge clk); #1;
    issue(4'd3, 32'hFFFF_FFFF, 32'd1, 5'd5, 1'b1);
    @(negedge clk);
    checks++;
    if (bif.out_result !== 32'd1) begin errors++; $display("FAIL slt_signed: got %h expected 1", bif.out_result); end
    @(posedge clk); #1;
    issue(4'd4, 32'hFFFF_FFFF, 32'd1, 5'd6, 1'b1);
    @(negedge clk);
    checks++;
    if (bif.out_result !== 32'd0) begin errors++; $display("FAIL sltu_unsigned: got %h expected 0", bif.out_result); end
    @(posedge clk); #1;
    for (int i = 0; i < 14; i++)
      issue(ops[i % 7], $urandom, $urandom, 5'(i + 8), 1'b1);
    wait_drain();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL arith_drain: %0d results missing, expected 0", sb.size()); end
  endtask

  task automatic shift_case(input string nm, input logic [3:0] c, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] t, input int lat_exp,
                            input logic [31:0] r_exp);
    int acc;
    int lat;
    int busy_bad = 0;
    bit seen = 1'b0;
    bif.out_ready = 1;
    issue(c, a, b, t, 1'b1);
    acc = cyc - 1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bif.out_valid) begin seen = 1'b1; break; end
      if (bif.in_ready) busy_bad++;
    end
    lat = cyc - acc;
    checks += 2;
    if (!seen || lat != lat_exp || bif.out_result !== r_exp) begin
      errors++;
      $display("FAIL %s: got valid=%b latency=%0d result=%h expected latency=%0d result=%h",
               nm, seen, lat, bif.out_result, lat_exp, r_exp);
    end
    if (busy_bad != 0) begin
      errors++;
      $display("FAIL %s_busy: in_ready high %0d cycles while shifting, expected 0", nm, busy_bad);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_shift();
    shift_case("sra_31", 4'd7, 32'h8000_0000, 32'h1F, 5'd1, 32, 32'hFFFF_FFFF);
    shift_case("srl_31", 4'd6, 32'h8000_0000, 32'h1F, 5'd2, 32, 32'h0000_0001);
    shift_case("sll_amt0", 4'd2, 32'h1234_5678, 32'h20, 5'd3, 1, 32'h1234_5678);
    shift_case("sll_4", 4'd2, 32'h8123_4567, 32'h64, 5'd4, 5, 32'h1234_5670);
    shift_case("sra_pos", 4'd7, 32'h7000_0000, 32'd3, 5'd5, 4, 32'h0E00_0000);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int t0;
    int p0;
    bif.out_ready = 1;
    t0 = cyc;
    for (int i = 0; i < 4; i++) issue(4'd0, 32'(i * 100), 32'd7, 5'(20 + i), 1'b1);
    checks++;
    if (cyc - t0 != 4) begin errors++; $display("FAIL throughput: 4 ops took %0d cycles, expected 4", cyc - t0); end
    wait_drain();
    // stall: consumer holds off for three cycles after the first result
    bif.out_ready = 0;
    p0 = pops;
    fork
      begin
        for (int i = 0; i < 4; i++) issue(4'd0, 32'h1000, 32'(i), 5'(24 + i), 1'b1);
      end
      begin
        logic [31:0] cap_r;
        logic [4:0]  cap_t;
        int bad = 0;
        bit seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
          @(negedge clk);
          if (bif.out_valid) begin seen = 1'b1; break; end
        end
        cap_r = bif.out_result; cap_t = bif.out_tag;
        for (int i = 0; i < 3; i++) begin
          if (i > 0) @(negedge clk);
          if (bif.out_result !== cap_r || bif.out_tag !== cap_t || !bif.out_valid || bif.in_ready) bad++;
        end
        @(posedge clk); #1; bif.out_ready = 1;
        checks += 2;
        if (!seen || cap_t !== 5'd24) begin errors++; $display("FAIL stall_first: got valid=%b tag=%0d expected 1 24", seen, cap_t); end
        if (bad != 0) begin errors++; $display("FAIL stall_hold: %0d unstable stall cycles, expected 0", bad); end
      end
    join
    wait_drain();
    checks++;
    if (pops - p0 != 4 || sb.size() != 0) begin
      errors++;
      $display("FAIL stall_count: got %0d outputs, %0d pending, expected 4 and 0", pops - p0, sb.size());
    end
  endtask

  task automatic test_illegal();
    bif.out_ready = 1;
    issue(4'hC, 32'h1234, 32'h5678, 5'd12, 1'b1);
    @(negedge clk);
    checks++;
    if (bif.out_valid !== 1'b1 || bif.out_err !== 1'b1 || bif.out_result !== 32'd0) begin
      errors++;
      $display("FAIL illegal_op: got valid=%b err=%b result=%h expected 1 1 0", bif.out_valid, bif.out_err, bif.out_result);
    end
    @(posedge clk); #1;
    issue(4'd0, 32'd40, 32'd2, 5'd13, 1'b1);
    @(negedge clk);
    checks++;
    if (bif.out_err !== 1'b0 || bif.out_result !== 32'd42) begin
      errors++;
      $display("FAIL illegal_recover: got err=%b result=%h expected 0 0000002a", bif.out_err, bif.out_result);
    end
    @(posedge clk); #1;
    issue(4'hF, 32'hFFFF_FFFF, 32'd1, 5'd14, 1'b1);
    wait_drain();
  endtask

  task automatic test_flush();
    bit seen = 1'b0;
    bif.out_ready = 1;
    issue(4'd2, 32'd1, 32'd10, 5'd17, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    flush = 1;
    bif.in_valid = 1; bif.in_alu_ctrl = 4'd0; bif.in_a = 32'd5; bif.in_b = 32'd6; bif.in_tag = 5'd18;
    @(negedge clk);
    checks++;
    if (bif.in_ready !== 1'b0) begin errors++; $display("FAIL flush_block: got in_ready=%b expected 0", bif.in_ready); end
    @(posedge clk); #1;
    flush = 0; bif.in_valid = 0;
    @(negedge clk);
    checks++;
    if (bif.in_ready !== 1'b1) begin errors++; $display("FAIL flush_idle: got in_ready=%b expected 1", bif.in_ready); end
    for (int k = 0; k < 15; k++) begin
      if (bif.out_valid) seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen) begin errors++; $display("FAIL flush_drop: got out_valid=1 after flush, expected 0"); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_shift();
    bif.out_ready = 1;
    issue(4'd0, 32'h0BAD_0000, 32'h0000_F00D, 5'd21, 1'b1);
    wait_drain();
    issue(4'd2, 32'd3, 32'd10, 5'd22, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 0;
    #1;
    checks++;
    if (bif.out_valid !== 1'b0 || bif.out_result !== 32'd0 || bif.out_tag !== 5'd0 ||
        bif.out_err !== 1'b0 || bif.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_shift: got valid=%b result=%h tag=%0d err=%b ready=%b expected all 0",
               bif.out_valid, bif.out_result, bif.out_tag, bif.out_err, bif.in_ready);
    end
    @(posedge clk); #1; rst_n = 1;
    @(posedge clk); #1;
    issue(4'd9, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd23, 1'b1);
    wait_drain();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL reset_recover: %0d results missing, expected 0", sb.size()); end
  endtask

  initial begin
    fork
      begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
      end
    join_none
    test_reset();
    test_arith();
    test_shift();
    test_back_to_back();
    test_illegal();
    test_flush();
    test_reset_mid_shift();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
